// File: rtl/orb_match_pkg.sv
// orb_match_pkg: shared state encoding and parameter defaults for the match scheduler.
// Rev 1.0
`default_nettype none

package orb_match_pkg;

  localparam int DATA_WIDTH_DEFAULT   = 16;
  localparam int DIST_LATENCY_DEFAULT = 3;
  localparam int DIST_LATENCY_MIN     = 1;
  localparam int DIST_LATENCY_MAX     = 8;
  localparam int IDX_WIDTH            = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SCAN     = 3'd2,
    DRAIN    = 3'd3,
    WAIT_RES = 3'd4,
    EMIT     = 3'd5,
    NEXT     = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/match_sched_delay.sv
// match_sched_delay: fixed-latency shift register carrying {en, location, last}.
// Rev 1.0
`default_nettype none

module match_sched_delay
  import orb_match_pkg::*;
#(
  parameter int LATENCY   = DIST_LATENCY_DEFAULT,
  parameter int LOC_WIDTH = IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LOC_WIDTH-1:0] loc,
  input  logic                 last,
  output logic                 en_dly,
  output logic [LOC_WIDTH-1:0] loc_dly,
  output logic                 last_dly
);

  localparam int W = LOC_WIDTH + 2;

  logic [W-1:0] pipe [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {en, loc, last};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {en_dly, loc_dly, last_dly} = pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/match_scheduler.sv
// match_scheduler: walks Q queries x T train descriptors, drives the min-finder and emits matches.
// Rev 1.0
`default_nettype none

module match_scheduler
  import orb_match_pkg::*;
#(
  parameter int Pra_Data_Width   = DATA_WIDTH_DEFAULT,
  parameter int Pra_Dist_Latency = DIST_LATENCY_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_go,
  input  logic [15:0]               i_query_num,
  input  logic [15:0]               i_train_num,
  input  logic [Pra_Data_Width-1:0] i_threshold,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_rd_en,
  output logic [15:0]               o_query_addr,
  output logic [15:0]               o_train_addr,
  output logic                      o_min_start,
  output logic                      o_min_en,
  output logic                      o_min_end,
  output logic [15:0]               o_min_location,
  input  logic                      i_min_ready,
  input  logic [Pra_Data_Width-1:0] i_min_data,
  input  logic [15:0]               i_min_location,
  output logic                      o_match_valid,
  input  logic                      i_match_ready,
  output logic [15:0]               o_match_query,
  output logic [15:0]               o_match_train,
  output logic [Pra_Data_Width-1:0] o_match_dist
);

  state_t                    state, state_nxt;
  logic [15:0]               qi, ti, q_num, t_num, cap_loc;
  logic [Pra_Data_Width-1:0] thr, cap_data;
  logic                      done_q;
  logic                      zero_frame, last_train, last_query;
  logic                      dl_en, dl_last;
  logic [15:0]               dl_loc;

  assign zero_frame = (i_query_num == 16'd0) || (i_train_num == 16'd0);
  assign last_train = (ti == t_num - 16'd1);
  assign last_query = (qi == q_num - 16'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_go && !zero_frame) state_nxt = START;
      START:    state_nxt = SCAN;
      SCAN:     if (last_train) state_nxt = DRAIN;
      DRAIN:    if (dl_en && dl_last) state_nxt = WAIT_RES;
      WAIT_RES: if (i_min_ready) state_nxt = (i_min_data <= thr) ? EMIT : NEXT;
      EMIT:     if (i_match_ready) state_nxt = NEXT;
      NEXT:     state_nxt = last_query ? IDLE : START;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      qi       <= '0;
      ti       <= '0;
      q_num    <= '0;
      t_num    <= '0;
      thr      <= '0;
      cap_data <= '0;
      cap_loc  <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_go) begin
            q_num  <= i_query_num;
            t_num  <= i_train_num;
            thr    <= i_threshold;
            qi     <= '0;
            done_q <= zero_frame;
          end
        end
        START: ti <= '0;
        SCAN:  if (!last_train) ti <= ti + 16'd1;
        WAIT_RES: begin
          if (i_min_ready) begin
            cap_data <= i_min_data;
            cap_loc  <= i_min_location;
          end
        end
        NEXT: begin
          if (last_query) done_q <= 1'b1;
          else            qi     <= qi + 16'd1;
        end
        default: ;
      endcase
    end
  end

  match_sched_delay #(
    .LATENCY   (Pra_Dist_Latency),
    .LOC_WIDTH (16)
  ) u_delay (
    .clk      (i_clk),
    .rst      (i_rst),
    .en       (o_rd_en),
    .loc      (o_train_addr),
    .last     (o_rd_en && last_train),
    .en_dly   (dl_en),
    .loc_dly  (dl_loc),
    .last_dly (dl_last)
  );

  // Address and match fields are gated to zero whenever their strobe is low.
  assign o_busy         = (state != IDLE);
  assign o_done         = done_q;
  assign o_rd_en        = (state == SCAN);
  assign o_query_addr   = o_rd_en ? qi : 16'd0;
  assign o_train_addr   = o_rd_en ? ti : 16'd0;
  assign o_min_start    = (state == START);
  assign o_min_en       = dl_en;
  assign o_min_end      = dl_last;
  assign o_min_location = dl_loc;
  assign o_match_valid  = (state == EMIT);
  assign o_match_query  = o_match_valid ? qi : 16'd0;
  assign o_match_train  = o_match_valid ? cap_loc : 16'd0;
  assign o_match_dist   = o_match_valid ? cap_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_match_scheduler.sv
// tb_match_scheduler: scoreboard bench with a behavioural min-finder for match_scheduler.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_match_scheduler;

  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_go = 1'b0;
  logic [15:0]   i_query_num = '0, i_train_num = '0;
  logic [DW-1:0] i_threshold = '0;
  logic          o_busy, o_done, o_rd_en, o_min_start, o_min_en, o_min_end, o_match_valid;
  logic [15:0]   o_query_addr, o_train_addr, o_min_location, o_match_query, o_match_train;
  logic [DW-1:0] o_match_dist;
  logic          i_min_ready;
  logic [DW-1:0] i_min_data;
  logic [15:0]   i_min_location;
  logic          i_match_ready = 1'b1;

  always #5 clk = ~clk;

  match_scheduler #(.Pra_Data_Width(DW), .Pra_Dist_Latency(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_go(i_go), .i_query_num(i_query_num),
    .i_train_num(i_train_num), .i_threshold(i_threshold), .o_busy(o_busy),
    .o_done(o_done), .o_rd_en(o_rd_en), .o_query_addr(o_query_addr),
    .o_train_addr(o_train_addr), .o_min_start(o_min_start), .o_min_en(o_min_en),
    .o_min_end(o_min_end), .o_min_location(o_min_location), .i_min_ready(i_min_ready),
    .i_min_data(i_min_data), .i_min_location(i_min_location),
    .o_match_valid(o_match_valid), .i_match_ready(i_match_ready),
    .o_match_query(o_match_query), .o_match_train(o_match_train),
    .o_match_dist(o_match_dist)
  );

  int          checks = 0, errors = 0;
  int          done_cnt = 0, rd_cnt = 0, start_cnt = 0;
  int          cur_t = 0;
  logic        spur_req = 1'b0;
  logic [47:0] exp_q[$];
  logic [15:0] dist_tab [4][8];
  logic [17:0] hist [LAT];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {o_busy, o_done, o_rd_en, o_query_addr, o_train_addr, o_min_start, o_min_en,
            o_min_end, o_min_location, o_match_valid, o_match_query, o_match_train, o_match_dist};
  endfunction

  // Output monitor: delay-line reference, event counters and match scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) hist[i] = '0;
    end else begin
      check("min_dly", {o_min_en, o_min_location, o_min_end}, hist[LAT-1]);
      if (o_min_start) check("en_with_start", o_min_en, 1'b0);
      for (int i = LAT-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {o_rd_en, o_train_addr, o_rd_en && (o_train_addr == 16'(cur_t - 1))};
      if (o_done) done_cnt++;
      if (o_rd_en) rd_cnt++;
      if (o_min_start) start_cnt++;
      if (o_match_valid) begin
        if (i_match_ready) begin
          if (exp_q.size() == 0) check("match_unexpected", 0, 1);
          else check("match", {o_match_query, o_match_train, o_match_dist}, exp_q.pop_front());
        end
      end else begin
        check("idle_fields", {o_match_query, o_match_train, o_match_dist}, 0);
      end
    end
  end

  // Behavioural min-finder: first strict minimum, result two cycles after o_min_end.
  initial begin
    logic [15:0] best, best_i, d;
    logic [1:0]  mf_q;
    int          cd;
    best = '1; best_i = '0; mf_q = '0; cd = 0;
    i_min_ready = 1'b0; i_min_data = '0; i_min_location = '0;
    forever begin
      @(negedge clk);
      i_min_ready = 1'b0; i_min_data = '0; i_min_location = '0;
      if (rst) begin
        cd = 0;
      end else begin
        if (spur_req) begin
          i_min_ready = 1'b1; i_min_data = '0; i_min_location = 16'd7;
          spur_req = 1'b0;
        end
        if (o_rd_en) mf_q = o_query_addr[1:0];
        if (o_min_start) begin best = '1; best_i = '0; end
        if (o_min_en) begin
          d = dist_tab[mf_q][o_min_location[2:0]];
          if (d < best) begin best = d; best_i = o_min_location; end
        end
        if (o_min_en && o_min_end) cd = 2;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            i_min_ready = 1'b1; i_min_data = best; i_min_location = best_i;
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame(input int q, input int t, input int th);
    logic [15:0] m, mi;
    for (int qq = 0; qq < q; qq++) begin
      m = '1; mi = '0;
      for (int tt = 0; tt < t; tt++)
        if (dist_tab[qq][tt] < m) begin m = dist_tab[qq][tt]; mi = 16'(tt); end
      if (m <= 16'(th)) exp_q.push_back({16'(qq), mi, m});
    end
    cur_t = t;
    i_query_num = 16'(q); i_train_num = 16'(t); i_threshold = 16'(th);
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0, n;
    c0 = done_cnt; n = 0;
    while (done_cnt == c0 && n < budget) begin tick(); n++; end
    check(tag, done_cnt - c0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, d0, n;
    logic [47:0] f0;
    for (int q = 0; q < 4; q++) for (int t = 0; t < 8; t++) dist_tab[q][t] = 16'd50;

    tick(2);
    check("reset_outs", outs(), 0);
    rst = 1'b0;

    // Single query, tie on minimum resolves to first index.
    dist_tab[0] = '{16'd9, 16'd4, 16'd7, 16'd4, 16'd50, 16'd50, 16'd50, 16'd50};
    s0 = start_cnt; r0 = rd_cnt;
    start_frame(1, 4, 5);
    wait_done("A_done", 100);
    check("A_left", exp_q.size(), 0);
    check("A_rd", rd_cnt - r0, 4);
    check("A_start", start_cnt - s0, 1);
    tick();
    check("A_idle", o_busy, 0);

    // Threshold boundary: q0 rejected, q1 accepted at equality.
    dist_tab[0] = '{16'd5, 16'd6, 16'd7, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
    dist_tab[1] = '{16'd3, 16'd2, 16'd4, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
    s0 = start_cnt;
    start_frame(2, 3, 2);
    wait_done("B_done", 100);
    check("B_left", exp_q.size(), 0);
    check("B_start", start_cnt - s0, 2);

    // Empty frame.
    s0 = start_cnt; r0 = rd_cnt;
    start_frame(0, 5, 10);
    check("C_done", o_done, 1);
    tick(3);
    check("C_rd", rd_cnt - r0, 0);
    check("C_start", start_cnt - s0, 0);
    check("C_busy", o_busy, 0);

    // Back-pressure on the match stream.
    i_match_ready = 1'b0;
    dist_tab[0] = '{16'd3, 16'd1, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
    start_frame(1, 2, 10);
    n = 0;
    while (!o_match_valid && n < 100) begin tick(); n++; end
    check("D_valid", o_match_valid, 1);
    f0 = {o_match_query, o_match_train, o_match_dist};
    s0 = start_cnt;
    repeat (10) begin
      tick();
      check("D_hold", {o_match_valid, o_match_query, o_match_train, o_match_dist}, {1'b1, f0});
    end
    check("D_no_start", start_cnt - s0, 0);
    i_match_ready = 1'b1;
    wait_done("D_done", 50);
    check("D_left", exp_q.size(), 0);

    // Reset while scanning the second query.
    dist_tab[0] = '{16'd5, 16'd3, 16'd8, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
    dist_tab[1] = '{16'd1, 16'd2, 16'd3, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50};
    start_frame(2, 3, 100);
    n = 0;
    while (!(o_rd_en && o_query_addr == 16'd1) && n < 100) begin tick(); n++; end
    check("E_reach", {o_rd_en, o_query_addr}, {1'b1, 16'd1});
    #1 rst = 1'b1;
    #1 check("E_rst_outs", outs(), 0);
    check("E_q0_seen", exp_q.size(), 1);
    exp_q.delete();
    d0 = done_cnt;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("E_no_done", done_cnt - d0, 0);
    dist_tab[0] = '{16'd9, 16'd4, 16'd7, 16'd4, 16'd50, 16'd50, 16'd50, 16'd50};
    start_frame(1, 4, 5);
    tick();
    check("E_restart_q", {o_rd_en, o_query_addr}, {1'b1, 16'd0});
    wait_done("E_done", 100);
    check("E_left", exp_q.size(), 0);

    // Disturbed rerun: go while busy and a stray min-finder strobe during SCAN.
    s0 = start_cnt; r0 = rd_cnt;
    start_frame(1, 4, 5);
    tick();
    spur_req = 1'b1;
    i_query_num = 16'd3; i_train_num = 16'd2; i_go = 1'b1;
    tick();
    i_go = 1'b0;
    wait_done("F_done", 100);
    check("F_left", exp_q.size(), 0);
    check("F_rd", rd_cnt - r0, 4);
    check("F_start", start_cnt - s0, 1);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
